// File: rtl/division_if.sv
// Operand/result bundle for the 32-bit iterative divider.
// The master drives the request and operands; the slave returns results and status.
interface division_if;
    logic        enable;
    logic        sign;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [1:0]  stateOut;
    logic        divZero;

    modport master (output enable, sign, A, B, input HI, LO, stateOut, divZero);
    modport slave  (input enable, sign, A, B, output HI, LO, stateOut, divZero);
endinterface

// File: rtl/division.sv
// 32-bit signed/unsigned restoring divider: one quotient bit per clock over 32 steps,
// with divide-by-zero detected at acceptance and a one-cycle DONE status.
module division (
    input  logic       clock,
    input  logic       reset,
    division_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [31:0] r_divisor;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic        r_negq;
    logic        r_negr;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_divzero;

    logic [32:0] w_rem_shift;
    logic [32:0] w_trial;
    logic        w_fits;
    logic [31:0] w_rem_next;
    logic [31:0] w_quot_next;

    function automatic logic [31:0] f_magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] f_cond_negate(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    // r_quot shifts the dividend out of its top while quotient bits enter at the bottom
    assign w_rem_shift = {r_rem, r_quot[31]};
    assign w_trial     = w_rem_shift - {1'b0, r_divisor};
    assign w_fits      = ~w_trial[32];
    assign w_rem_next  = w_fits ? w_trial[31:0] : w_rem_shift[31:0];
    assign w_quot_next = {r_quot[30:0], w_fits};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= 5'd0;
            r_divisor <= 32'd0;
            r_quot    <= 32'd0;
            r_rem     <= 32'd0;
            r_negq    <= 1'b0;
            r_negr    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_divzero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_divisor <= f_magnitude(bus.B, bus.sign);
                        r_quot    <= f_magnitude(bus.A, bus.sign);
                        r_rem     <= 32'd0;
                        r_count   <= 5'd0;
                        r_negq    <= bus.sign & (bus.A[31] ^ bus.B[31]);
                        r_negr    <= bus.sign & bus.A[31];
                        if (bus.B == 32'd0) begin
                            r_state   <= S_DONE;
                            r_divzero <= 1'b1;
                        end else begin
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem   <= w_rem_next;
                    r_quot  <= w_quot_next;
                    r_count <= r_count + 5'd1;
                    // Results become visible only on the final step
                    if (r_count == 5'd31) begin
                        r_lo    <= f_cond_negate(w_quot_next, r_negq);
                        r_hi    <= f_cond_negate(w_rem_next, r_negr);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_divzero <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.HI       = r_hi;
    assign bus.LO       = r_lo;
    assign bus.stateOut = r_state;
    assign bus.divZero  = r_divzero;
endmodule

// File: doc/division.md
DIVISION -- requirements
Module: division

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-004 enable  input  1  start request; honoured only in IDLE.
REQ-005 sign  input  1  1 = signed (div), 0 = unsigned (divu); captured with operands.
REQ-006 A  input  32  dividend; captured on the accepting edge.
REQ-007 B  input  32  divisor; captured on the accepting edge.
REQ-008 HI  output  32  remainder of last completed division.
REQ-009 LO  output  32  quotient of last completed division.
REQ-010 stateOut  output  2  0 = IDLE, 1 = RUN, 2 = DONE; 3 never driven.
REQ-011 divZero  output  1  high only in a DONE cycle caused by B == 0.

Function
REQ-012 FSM states: IDLE, RUN, DONE; stateOut encodes the current state per REQ-010.
REQ-013 IDLE with enable = 1 at edge E0: A, B and sign are latched; if B != 0, go to RUN with the iteration counter at 0; if B == 0, go to DONE with divZero = 1.
REQ-014 IDLE with enable = 0: hold the state; HI and LO hold their values.
REQ-015 RUN: one restoring-division step (shift, trial subtract, quotient bit) per edge on operand magnitudes; 32 steps at E1..E32.
REQ-016 At E32: LO and HI are written with the final results and the state goes to DONE; HI and LO stay unchanged during RUN.
REQ-017 DONE lasts exactly one cycle; the next edge returns to IDLE and clears divZero.
REQ-018 Latency, B != 0: stateOut = 2 and results are valid after E32 (32 cycles after acceptance); a new request is accepted no earlier than E34.
REQ-019 Latency, B == 0: stateOut = 2 after E0; HI and LO keep their previous values.
REQ-020 enable asserted in RUN or DONE is ignored; it is not queued.
REQ-021 A and B changing after E0 have no effect on the result.
REQ-022 Signed mode: quotient truncates toward zero; remainder takes the sign of the dividend; |HI| < |B|.
REQ-023 Signed mode: magnitudes are taken by two's-complement negation, and results are negated when the signs require it.
REQ-024 Signed mode: 0x80000000 / 0xFFFFFFFF yields LO = 0x80000000, HI = 0 (wrap); no flag is raised.
REQ-025 Unsigned mode: operands are treated as 32-bit unsigned; no negation is applied.
REQ-026 A == 0 with B != 0 yields LO = 0, HI = 0 after the full 32-step latency.

Reset
REQ-027 reset = 0 at any edge: state = IDLE, counter = 0, HI = 0, LO = 0, divZero = 0, and internal operand registers are cleared.
REQ-028 reset takes priority over enable and over any in-progress operation; an aborted division leaves no result in HI or LO.
REQ-029 The first edge with reset = 1 may accept enable.

Verification
REQ-030 Signed positive: sign = 1, A = 7, B = 2, pulse enable -> stateOut = 1 for 32 cycles, then stateOut = 2 with LO = 3, HI = 1, divZero = 0, then stateOut = 0.
REQ-031 Signed negative: sign = 1, A = 0xFFFFFFF9, B = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
REQ-032 Unsigned: sign = 0, A = 0xFFFFFFF9, B = 2 -> LO = 0x7FFFFFFC, HI = 1.
REQ-033 Divide by zero: after REQ-030, A = 5, B = 0 -> next cycle stateOut = 2, divZero = 1, LO = 3, HI = 1 unchanged; following cycle stateOut = 0, divZero = 0.
REQ-034 Overflow case: sign = 1, A = 0x80000000, B = 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
REQ-035 Reset mid-run: start A = 100, B = 7; drive reset = 0 at RUN step 10 -> stateOut = 0, HI = 0, LO = 0. Release reset and restart -> LO = 14, HI = 2 after 32 cycles. Holding enable high throughout RUN triggers no extra operation.
